// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus sequencer: turns decoder load/store strobes into one handshaked
// bus transaction each, stalling the PC until the access completes or fails.
module mio_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              MIO_ready,
    input  logic [DATA_W-1:0] Data_in,
    output logic              CPU_MIO,
    output logic [ADDR_W-1:0] Addr_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              mem_w,
    output logic [DATA_W-1:0] rdata_out,
    output logic              stall,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_cpu_mio;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_mem_w;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_bus_err;
    logic               r_err_rd;

    logic               w_req;
    logic               w_aligned;
    logic               w_last_wait;

    assign w_req       = MemRead | MemWrite;
    assign w_aligned   = (addr_in[1:0] == 2'b00);
    assign w_last_wait = (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_cpu_mio  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_mem_w    <= 1'b0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_err_rd   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_aligned) begin
                            r_addr     <= addr_in;
                            r_data     <= wdata_in;
                            r_mem_w    <= MemWrite;
                            r_wait_cnt <= '0;
                            r_cpu_mio  <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            // Bus-visible latches stay untouched; only remember direction for ERR.
                            r_err_rd <= ~MemWrite;
                            r_state  <= S_ERR;
                        end
                    end
                end
                S_REQ: begin
                    // Ready wins over timeout in the last permitted cycle.
                    if (MIO_ready) begin
                        if (!r_mem_w) begin
                            r_rdata <= Data_in;
                        end
                        r_cpu_mio <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (w_last_wait) begin
                        r_err_rd  <= ~r_mem_w;
                        r_cpu_mio <= 1'b0;
                        r_state   <= S_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_bus_err <= 1'b1;
                    if (r_err_rd) begin
                        r_rdata <= '0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CPU_MIO   = r_cpu_mio;
    assign Addr_out  = r_addr;
    assign Data_out  = r_data;
    assign mem_w     = r_mem_w;
    assign rdata_out = r_rdata;
    assign bus_err   = r_bus_err;
    assign stall     = ((r_state == S_IDLE) && w_req) || (r_state == S_REQ);

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: directed transaction table, cycle-exact corner
// sequences, then random transactions checked against a transaction-level model.
module tb_mio_bus_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          MemRead, MemWrite, MIO_ready;
    logic [AW-1:0] addr_in, Addr_out;
    logic [DW-1:0] wdata_in, Data_in, Data_out, rdata_out;
    logic          CPU_MIO, mem_w, stall, bus_err;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic          m_mw;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            k;      // ready arrives in REQ cycle k+1
        logic [DW-1:0] bd;
        int            e_nreq;
        int            e_nstall;
        logic          e_err;
        logic [DW-1:0] e_rdata;
    } vec_t;

    always #5 clk = ~clk;

    mio_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr_in(addr_in), .wdata_in(wdata_in), .MIO_ready(MIO_ready),
        .Data_in(Data_in), .CPU_MIO(CPU_MIO), .Addr_out(Addr_out),
        .Data_out(Data_out), .mem_w(mem_w), .rdata_out(rdata_out),
        .stall(stall), .bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        MemRead = 0; MemWrite = 0; addr_in = '0; wdata_in = '0;
        MIO_ready = 0; Data_in = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        m_addr = '0; m_wd = '0; m_mw = 0;
        @(negedge clk);
        chk("rst_cpu_mio", CPU_MIO, 0);
        chk("rst_addr", Addr_out, 0);
        chk("rst_data", Data_out, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bus_err", bus_err, 0);
        tick();
    endtask

    // Drives one instruction; holds the strobes while stalled, scrambles decoder
    // inputs afterwards (must be ignored), and counts REQ and stall cycles.
    task automatic run_txn(input vec_t v, output int nreq, output int nstall);
        bit done = 0;
        nreq = 0; nstall = 0;
        MemRead = v.rd; MemWrite = v.wr; addr_in = v.a; wdata_in = v.wd;
        MIO_ready = 1'($urandom_range(0, 1)); Data_in = $urandom;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (CPU_MIO) begin
                nreq++;
                chk("req_addr", Addr_out, v.a);
                chk("req_mem_w", mem_w, v.wr);
                chk("req_wdata", Data_out, v.wd);
                MIO_ready = (nreq == v.k + 1);
                Data_in = (nreq == v.k + 1) ? v.bd : DW'($urandom);
            end else begin
                MIO_ready = 1'($urandom_range(0, 1));
                Data_in = $urandom;
            end
            if (!stall) done = 1;
            tick();
            if (done) begin
                MemRead = 0; MemWrite = 0;
            end else begin
                MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
                addr_in = $urandom; wdata_in = $urandom;
            end
        end
        if (!done) chk("txn_hang", 0, 1);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int nreq, nstall;
        run_txn(v, nreq, nstall);
        if ((v.rd | v.wr) && v.a[1:0] == 2'b00) begin
            m_addr = v.a; m_wd = v.wd; m_mw = v.wr;
        end
        @(negedge clk);
        chk({tag, "_nreq"}, nreq, v.e_nreq);
        chk({tag, "_nstall"}, nstall, v.e_nstall);
        chk({tag, "_bus_err"}, bus_err, v.e_err);
        chk({tag, "_rdata"}, rdata_out, v.e_rdata);
        chk({tag, "_addr"}, Addr_out, m_addr);
        chk({tag, "_dout"}, Data_out, m_wd);
        chk({tag, "_mem_w"}, mem_w, m_mw);
        chk({tag, "_idle_stall"}, stall, 0);
        chk({tag, "_idle_mio"}, CPU_MIO, 0);
        tick();
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0, 32'h10, 32'h0,         0, 32'hCAFE_F00D, 1, 2, 0, 32'hCAFE_F00D};
        tbl[1]  = '{0, 1, 32'h20, 32'h1234_5678, 3, 32'h0,         4, 5, 0, 32'hCAFE_F00D};
        tbl[2]  = '{1, 0, 32'h30, 32'h0,         3, 32'hA5A5_0001, 4, 5, 0, 32'hA5A5_0001};
        tbl[3]  = '{0, 0, 32'h33, 32'h0,         0, 32'h0,         0, 0, 0, 32'hA5A5_0001};
        tbl[4]  = '{1, 1, 32'h40, 32'hDEAD_BEEF, 1, 32'h0,         2, 3, 0, 32'hA5A5_0001};
        tbl[5]  = '{1, 0, 32'h44, 32'h0,         4, 32'h0,         4, 5, 1, 32'h0};
        tbl[6]  = '{1, 0, 32'h08, 32'h0,         2, 32'h1111_2222, 3, 4, 0, 32'h1111_2222};
        tbl[7]  = '{1, 0, 32'h06, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0};
        tbl[8]  = '{1, 0, 32'h10, 32'h0,         0, 32'h3333_4444, 1, 2, 1, 32'h3333_4444};
        tbl[9]  = '{0, 1, 32'h21, 32'h5555_6666, 0, 32'h0,         0, 1, 1, 32'h3333_4444};
        tbl[10] = '{0, 1, 32'h24, 32'h7777_8888, 5, 32'h0,         4, 5, 1, 32'h3333_4444};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i == 6) do_reset();
            do_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the 2nd REQ cycle abandons the access without flagging an error.
        MemRead = 1; MemWrite = 0; addr_in = 32'h50; wdata_in = 32'h9; MIO_ready = 0;
        @(negedge clk); chk("mid_c0_stall", stall, 1);
        tick();
        @(negedge clk); chk("mid_req1_mio", CPU_MIO, 1);
        tick();
        @(negedge clk); chk("mid_req2_mio", CPU_MIO, 1);
        rst = 1;
        tick();
        rst = 0; MemRead = 0;
        m_addr = '0; m_wd = '0; m_mw = 0;
        @(negedge clk);
        chk("mid_rst_mio", CPU_MIO, 0);
        chk("mid_rst_addr", Addr_out, 0);
        chk("mid_rst_dout", Data_out, 0);
        chk("mid_rst_mem_w", mem_w, 0);
        chk("mid_rst_rdata", rdata_out, 0);
        chk("mid_rst_err", bus_err, 0);
        chk("mid_rst_stall", stall, 0);
        tick();
        do_txn('{1, 0, 32'h60, 32'h0, 0, 32'hBEEF_0001, 1, 2, 0, 32'hBEEF_0001}, "post_rst");

        // Cycle-exact aligned load, then ALU instruction right after DONE.
        MemRead = 1; addr_in = 32'h70; MIO_ready = 0;
        @(negedge clk);
        chk("ce_c0_stall", stall, 1); chk("ce_c0_mio", CPU_MIO, 0);
        tick();
        MemRead = 0;
        @(negedge clk);
        chk("ce_c1_stall", stall, 1); chk("ce_c1_mio", CPU_MIO, 1);
        MIO_ready = 1; Data_in = 32'h0BAD_CAFE;
        tick();
        MemRead = 1; MemWrite = 1; MIO_ready = 0;
        @(negedge clk);
        chk("ce_c2_stall", stall, 0); chk("ce_c2_mio", CPU_MIO, 0);
        chk("ce_c2_rdata", rdata_out, 32'h0BAD_CAFE);
        tick();
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        chk("ce_alu_stall", stall, 0); chk("ce_alu_mio", CPU_MIO, 0);
        tick();
        @(negedge clk);
        chk("ce_no_dup_mio", CPU_MIO, 0);
        tick();

        // Random transactions against a transaction-level model.
        do_reset();
        begin
            logic          m_err = 0;
            logic [DW-1:0] m_rdata = '0;
            for (int n = 0; n < 200; n++) begin
                vec_t v;
                int   op = $urandom_range(0, 3);
                bit   req, al, ok;
                v.rd = op[0]; v.wr = op[1];
                v.a  = $urandom;
                if ($urandom_range(0, 3) != 0) v.a[1:0] = 2'b00;
                v.wd = $urandom; v.bd = $urandom;
                v.k  = $urandom_range(0, TO + 1);
                req = v.rd | v.wr;
                al  = (v.a[1:0] == 2'b00);
                ok  = al && (v.k + 1 <= TO);
                v.e_nreq   = (req && al) ? ((v.k + 1 < TO) ? v.k + 1 : TO) : 0;
                v.e_nstall = req ? v.e_nreq + 1 : 0;
                if (req && !ok) m_err = 1;
                if (req && !v.wr) m_rdata = ok ? v.bd : '0;
                v.e_err = m_err; v.e_rdata = m_rdata;
                do_txn(v, $sformatf("rnd%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
